// File: rtl/mem_port_arbiter_if.sv
// Bundle between the fetch/data requesters, the arbiter and the shared single-port memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MASK_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [MASK_W-1:0] d_wmask;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_we, mem_wdata, mem_wmask
    );

    // Requesters plus memory model side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_we, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access: data wins by default,
// fetch is forced through after STARVE_MAX consecutive denied cycles.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } resp_state_t;

    resp_state_t       state;
    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic starved;
    logic i_win;
    logic d_win;
    logic i_gnt_c;
    logic d_gnt_c;

    // Arbitration; flops use the ungated winners since they are held in reset anyway
    always_comb begin
        starved = (starve_cnt == CNT_W'(STARVE_MAX));
        i_win   = bus.i_req & (~bus.d_req | starved);
        d_win   = bus.d_req & ~i_win;
        i_gnt_c = rst & i_win;
        d_gnt_c = rst & d_win;
    end

    assign bus.i_gnt     = i_gnt_c;
    assign bus.d_gnt     = d_gnt_c;
    assign bus.mem_addr  = i_gnt_c ? bus.i_addr : (d_gnt_c ? bus.d_addr : addr_q);
    assign bus.mem_wdata = d_gnt_c ? bus.d_wdata : wdata_q;
    assign bus.mem_we    = d_gnt_c & bus.d_we;
    assign bus.mem_wmask = (d_gnt_c & bus.d_we) ? bus.d_wmask : MASK_W'(0);

    // Response owner follows the memory's one-cycle read latency
    assign bus.i_rvalid = (state == RESP_I);
    assign bus.d_rvalid = (state == RESP_D);
    assign bus.i_rdata  = (state == RESP_I) ? bus.mem_rdata : DATA_W'(0);
    assign bus.d_rdata  = (state == RESP_D) ? bus.mem_rdata : DATA_W'(0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= CNT_W'(0);
            addr_q     <= ADDR_W'(0);
            wdata_q    <= DATA_W'(0);
        end else begin
            if (i_win) begin
                state <= RESP_I;
            end else if (d_win) begin
                state <= RESP_D;
            end else begin
                state <= IDLE;
            end

            if (!bus.i_req || i_win) begin
                starve_cnt <= CNT_W'(0);
            end else if (!starved) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end

            // Idle port keeps the last presented address and write data
            if (i_win) begin
                addr_q <= bus.i_addr;
            end else if (d_win) begin
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
            end
        end
    end
endmodule
